// File: rtl/pump_output_driver.sv
// rtl/pump_output_driver.sv - pump drive stage: one-hot arbitration, dead gap, cooldown, max-on fault
module pump_output_driver #(
    parameter int CLOCK_FREQ    = 1_000_000,
    parameter int TICK_HZ       = 1000,
    parameter int MAX_ON_TICKS  = 10000,
    parameter int MIN_OFF_TICKS = 2000,
    parameter int DEAD_TICKS    = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] pump_req,
    input  logic       enable,
    input  logic       fault_clr,
    output logic [2:0] drive_out,
    output logic [1:0] active_id,
    output logic       busy,
    output logic [2:0] fault
);

    localparam int DIV = CLOCK_FREQ / TICK_HZ;
    localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int ONW = (MAX_ON_TICKS > 1) ? $clog2(MAX_ON_TICKS) : 1;
    localparam int COW = (MIN_OFF_TICKS > 0) ? $clog2(MIN_OFF_TICKS + 1) : 1;
    localparam int GW  = (DEAD_TICKS > 1) ? $clog2(DEAD_TICKS) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [PW-1:0]       presc_q, presc_d;
    logic [ONW-1:0]      on_q, on_d;
    logic [GW-1:0]       gap_q, gap_d;
    logic [2:0][COW-1:0] cool_q, cool_d;
    logic [1:0]          rr_q, rr_d;
    logic [2:0]          drive_q, drive_d;
    logic [1:0]          id_q, id_d;
    logic [2:0]          fault_q, fault_d;

    logic       tick;
    logic [2:0] elig;
    logic       grant_found;
    logic [1:0] grant_idx;
    logic [1:0] scan_idx;
    logic       cutoff;
    logic       drive_exit;

    function automatic logic [1:0] next_idx(input logic [1:0] v);
        next_idx = (v == 2'd2) ? 2'd0 : v + 2'd1;
    endfunction

    assign tick = (presc_q == PW'(DIV - 1));

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            elig[i] = pump_req[i] && !fault_q[i] && (cool_q[i] == '0) && enable;
        end
    end

    // Scan starting at the round-robin pointer; the first eligible pump wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = 2'd0;
        scan_idx    = rr_q;
        for (int k = 0; k < 3; k++) begin
            if (!grant_found && elig[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
            scan_idx = next_idx(scan_idx);
        end
    end

    assign cutoff     = (state_q == S_DRIVE) && tick && (on_q == ONW'(MAX_ON_TICKS - 1));
    assign drive_exit = (state_q == S_DRIVE) &&
                        (!(|(pump_req & drive_q)) || !enable || cutoff);

    always_comb begin
        state_d = state_q;
        presc_d = tick ? '0 : presc_q + 1'b1;
        on_d    = on_q;
        gap_d   = gap_q;
        rr_d    = rr_q;
        drive_d = drive_q;
        id_d    = id_q;
        fault_d = fault_clr ? 3'b000 : fault_q;
        for (int i = 0; i < 3; i++) begin
            cool_d[i] = (tick && cool_q[i] != '0) ? cool_q[i] - 1'b1 : cool_q[i];
        end

        case (state_q)
            S_IDLE: begin
                if (grant_found) begin
                    state_d = S_DRIVE;
                    drive_d = 3'b001 << grant_idx;
                    id_d    = grant_idx + 2'd1;
                    on_d    = '0;
                    rr_d    = next_idx(grant_idx);
                end
            end
            S_DRIVE: begin
                if (tick) begin
                    on_d = on_q + 1'b1;
                end
                if (drive_exit) begin
                    state_d = S_GAP;
                    drive_d = 3'b000;
                    id_d    = 2'd0;
                    gap_d   = '0;
                    for (int i = 0; i < 3; i++) begin
                        if (drive_q[i]) begin
                            cool_d[i] = COW'(MIN_OFF_TICKS);
                        end
                    end
                    // A set on the same edge as fault_clr must survive.
                    if (cutoff) begin
                        fault_d = fault_d | drive_q;
                    end
                end
            end
            S_GAP: begin
                if (DEAD_TICKS == 0) begin
                    state_d = S_IDLE;
                end else if (tick) begin
                    gap_d = gap_q + 1'b1;
                    if (gap_q == GW'(DEAD_TICKS - 1)) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                drive_d = 3'b000;
                id_d    = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            presc_q <= '0;
            on_q    <= '0;
            gap_q   <= '0;
            cool_q  <= '0;
            rr_q    <= 2'd0;
            drive_q <= 3'b000;
            id_q    <= 2'd0;
            fault_q <= 3'b000;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            on_q    <= on_d;
            gap_q   <= gap_d;
            cool_q  <= cool_d;
            rr_q    <= rr_d;
            drive_q <= drive_d;
            id_q    <= id_d;
            fault_q <= fault_d;
        end
    end

    assign drive_out = drive_q;
    assign active_id = id_q;
    assign busy      = (state_q != S_IDLE);
    assign fault     = fault_q;

endmodule

// File: tb/tb_pump_output_driver.sv
// tb/tb_pump_output_driver.sv - directed bench for pump_output_driver (tick = 10 cycles)
module tb_pump_output_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] pump_req = 3'b000;
    logic       enable = 1'b1;
    logic       fault_clr = 1'b0;
    logic [2:0] drive_out;
    logic [1:0] active_id;
    logic       busy;
    logic [2:0] fault;

    int n_cmp = 0;
    int n_err = 0;
    int tb_presc = 0;
    int tick_total = 0;

    pump_output_driver #(
        .CLOCK_FREQ   (1000),
        .TICK_HZ      (100),
        .MAX_ON_TICKS (8),
        .MIN_OFF_TICKS(5),
        .DEAD_TICKS   (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .pump_req (pump_req),
        .enable   (enable),
        .fault_clr(fault_clr),
        .drive_out(drive_out),
        .active_id(active_id),
        .busy     (busy),
        .fault    (fault)
    );

    always #5 clk = ~clk;

    // Reference tick: one every 10 cycles, phase restarted by reset.
    always @(posedge clk) begin
        if (rst) begin
            tb_presc <= 0;
        end else begin
            tb_presc <= (tb_presc == 9) ? 0 : tb_presc + 1;
            if (tb_presc == 9) tick_total <= tick_total + 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy === 1'b1 && k < 200) begin
            step();
            k++;
        end
    endtask

    initial begin
        int t0;
        int zc;
        int bad;
        int k;
        logic [2:0] exp_oh;

        rst = 1'b1;
        step();
        chk("rst_drive", drive_out, 3'b000);
        chk("rst_id", active_id, 2'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_fault", fault, 3'b000);
        rst = 1'b0;

        pump_req = 3'b001;
        step();
        chk("basic_drive", drive_out, 3'b001);
        chk("basic_id", active_id, 2'd1);
        chk("basic_busy", busy, 1'b1);
        bad = 0;
        for (int i = 0; i < 29; i++) begin
            step();
            if (drive_out !== 3'b001) bad++;
        end
        chk("basic_hold", bad, 0);
        pump_req = 3'b000;
        step();
        t0 = tick_total;
        chk("basic_release", drive_out, 3'b000);
        chk("basic_release_id", active_id, 2'd0);
        chk("basic_gap_busy", busy, 1'b1);
        wait_idle();
        chk("basic_gap_ticks", tick_total - t0, 2);
        chk("basic_fault", fault, 3'b000);

        pump_req = 3'b001;
        k = 0;
        while (drive_out === 3'b000 && k < 200) begin
            step();
            k++;
        end
        chk("cool_ticks", tick_total - t0, 5);
        chk("cool_drive", drive_out, 3'b001);
        pump_req = 3'b000;
        step();
        wait_idle();

        rst = 1'b1;
        step();
        rst = 1'b0;
        pump_req = 3'b111;
        bad = 0;
        for (int g = 0; g < 4; g++) begin
            exp_oh = 3'b001 << (g % 3);
            zc = 0;
            while (drive_out === 3'b000 && zc < 300) begin
                step();
                zc++;
                if ($countones(drive_out) > 1) bad++;
            end
            chk($sformatf("rr_grant%0d", g), drive_out, exp_oh);
            chk($sformatf("rr_id%0d", g), active_id, (g % 3) + 1);
            if (g > 0) chk($sformatf("rr_gap%0d", g), (zc >= 10), 1'b1);
            for (int i = 0; i < 3; i++) begin
                step();
                if ($countones(drive_out) > 1) bad++;
            end
            pump_req = 3'b111 & ~drive_out;
            step();
            chk($sformatf("rr_release%0d", g), drive_out, 3'b000);
            pump_req = 3'b111;
        end
        chk("rr_onehot", bad, 0);
        pump_req = 3'b000;
        wait_idle();

        rst = 1'b1;
        step();
        rst = 1'b0;
        pump_req = 3'b010;
        step();
        chk("maxon_grant", drive_out, 3'b010);
        t0 = tick_total;
        k = 0;
        while (drive_out === 3'b010 && k < 200) begin
            step();
            k++;
        end
        chk("maxon_ticks", tick_total - t0, 8);
        chk("maxon_drop", drive_out, 3'b000);
        chk("maxon_fault", fault, 3'b010);
        t0 = tick_total;
        wait_idle();
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (drive_out !== 3'b000) bad++;
        end
        chk("maxon_no_regrant", bad, 0);
        fault_clr = 1'b1;
        step();
        fault_clr = 1'b0;
        chk("maxon_clr", fault, 3'b000);
        k = 0;
        while (drive_out === 3'b000 && k < 200) begin
            step();
            k++;
        end
        chk("maxon_regrant_ticks", tick_total - t0, 5);
        chk("maxon_regrant", drive_out, 3'b010);
        pump_req = 3'b000;
        step();
        wait_idle();

        pump_req = 3'b100;
        step();
        chk("en_grant", drive_out, 3'b100);
        step();
        step();
        enable = 1'b0;
        step();
        chk("en_drop", drive_out, 3'b000);
        chk("en_busy", busy, 1'b1);
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (drive_out !== 3'b000) bad++;
        end
        chk("en_no_grant", bad, 0);
        chk("en_gap_done", busy, 1'b0);
        enable = 1'b1;
        pump_req = 3'b000;

        rst = 1'b1;
        step();
        rst = 1'b0;
        pump_req = 3'b001;
        step();
        chk("col_grant", drive_out, 3'b001);
        t0 = tick_total;
        k = 0;
        while (!((tick_total - t0) == 7 && tb_presc == 9) && k < 200) begin
            step();
            k++;
        end
        fault_clr = 1'b1;
        step();
        fault_clr = 1'b0;
        chk("col_drop", drive_out, 3'b000);
        chk("col_fault", fault, 3'b001);

        pump_req = 3'b100;
        k = 0;
        while (drive_out === 3'b000 && k < 200) begin
            step();
            k++;
        end
        chk("rstmid_grant", drive_out, 3'b100);
        step();
        step();
        rst = 1'b1;
        step();
        chk("rstmid_drive", drive_out, 3'b000);
        chk("rstmid_id", active_id, 2'd0);
        chk("rstmid_busy", busy, 1'b0);
        chk("rstmid_fault", fault, 3'b000);
        rst = 1'b0;
        pump_req = 3'b111;
        step();
        chk("rstmid_prio", drive_out, 3'b001);
        chk("rstmid_prio_id", active_id, 2'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
